universal_reg_n: RTL and testbench
==================================

Name: universal_reg_n

Overview:
- Parametrised successor to the team's fixed 4-bit load/clear register.
- An N-bit register that keeps the legacy single-cycle parallel load and synchronous clear.
- Adds a command port that runs a multi-cycle operation: shift, rotate, increment or decrement, repeated `amt` times.
- Sits on datapaths that need a loadable, shiftable or countable register with a busy/done handshake toward a controller.

Parameters:
- WIDTH, 8: register width in bits; minimum 2.
- AMT_W, 4: width of the repeat-count input; maximum `amt` is 2^AMT_W-1.

Ports:
- clk  input  1  clock; all state changes on its rising edge.
- clear  input  1  synchronous active-high reset.
- load  input  1  legacy parallel load; honoured only in IDLE when `start`=0.
- i  input  WIDTH  parallel data, used by `load` and by op LOAD.
- start  input  1  command strobe; sampled in IDLE only.
- op  input  3  operation code, latched when `start` is accepted.
- amt  input  AMT_W  repeat count, latched when `start` is accepted.
- sin  input  1  serial-in bit for SHL/SHR; sampled on every step.
- a  output  WIDTH  register contents.
- sout  output  1  registered copy of the last bit shifted or rotated out.
- busy  output  1  high while the FSM is in RUN.
- done  output  1  one-cycle pulse when a command completes.
- zero  output  1  combinational flag, high when `a`==0.

Behaviour:
- Reset: on `clear`=1 at a rising edge, the following are forced, regardless of state:
  - `a`=0, `sout`=0, `busy`=0, `done`=0
  - FSM goes to IDLE, repeat counter=0
  - Reset mid-RUN aborts the command; no `done` pulse is produced.
- Priority at each edge: `clear` > `start` (IDLE) > `load` (IDLE) > hold.
- Op codes:
  - 000 HOLD
  - 001 LOAD (`a`<=`i`)
  - 010 SHL (`a`<={a[W-2:0],sin}, sout<=a[W-1])
  - 011 SHR (`a`<={sin,a[W-1:1]}, sout<=a[0])
  - 100 ROL (sout<=a[W-1])
  - 101 ROR (sout<=a[0])
  - 110 INC (`a`<=`a`+1, modulo 2^WIDTH)
  - 111 DEC (`a`<=`a`-1, modulo 2^WIDTH)
- `sout` changes only on shift/rotate steps.
- FSM has two states: IDLE and RUN.
- IDLE, `start`=1, accept edge E0:
  - latch `op`; latch the step count, where LOAD forces count=1 and HOLD uses `amt` (only the timing is exercised).
  - if count>0: go to RUN, counter<=count; `a` is unchanged at E0.
  - if count==0: stay in IDLE; `done`=1 for the cycle after E0; `a` is unchanged.
- RUN: one step is applied at each edge and the counter decrements.
  - At the edge where counter==1, the final step is applied, the FSM returns to IDLE, and `done`=1 for the following cycle.
  - Result: `busy` is high for exactly count cycles, steps land at edges E1..E_count, and `done` is high after E_count.
- In RUN, `start`, `load`, `op` and `amt` are ignored; `i` is read only by op LOAD.
- `done` and `busy` are never high together.
- A new `start` is accepted in the same cycle that `done` is high, since the FSM is back in IDLE.
- `load` in IDLE: `a`<=`i` at the next edge, no `done` pulse. This is identical to the legacy block.

Optional Feature:
- Macro UREG_CARRY_EN.
- Defined: adds output port `carry` (1 bit, reset 0).
  - `carry` is cleared at command accept.
  - Then, for each step in RUN, it ORs in the overflow/borrow of INC/DEC (FF->00 or 00->FF for WIDTH=8) and the bit shifted out by SHL/SHR.
  - `carry` holds its value after `done` until the next accept or `clear`.
  - A legacy `load` leaves `carry` unchanged.
- Undefined: no `carry` port and no carry logic.

Test Plan (WIDTH=8, AMT_W=4):
- Reset: `clear`=1 for one edge from any state -> `a`=00, `busy`=0, `done`=0, `sout`=0, `zero`=1.
- Legacy load: IDLE, `load`=1, `i`=A5 -> `a`=A5 after one edge, no `done`.
- Rotate: `a`=A5, `start` with op=ROL, `amt`=3 -> `busy` high for 3 cycles, `a`=4B, 96, 2D, `sout`=1,0,1, then `done` for one cycle.
- Increment wrap: `a`=FE, op=INC, `amt`=3 -> `a`=FF, 00, 01, `done` pulse; `carry`=1 with the macro defined. Also `amt`=0 -> `done` after E0 with `a` unchanged.
- Clear mid-RUN: op=SHR, `amt`=5, `sin`=1, `a`=00; after 2 steps (`a`=C0) assert `clear` -> `a`=00, `busy`=0, no `done` pulse afterwards.
- Ignored inputs while busy: in RUN pulse `start` (op=LOAD) and `load` with `i`=3C -> no effect; the original command completes with the correct count and a single `done`.

Source files
------------

// File: rtl/universal_reg_n.sv
// N-bit load/clear register with a multi-cycle shift/rotate/count command port.
// Define UREG_CARRY_EN to add the sticky `carry` output.
module universal_reg_n #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned AMT_W = 4
) (
  input  logic             clk,
  input  logic             clear,
  input  logic             load,
  input  logic [WIDTH-1:0] i,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [AMT_W-1:0] amt,
  input  logic             sin,
  output logic [WIDTH-1:0] a,
  output logic             sout,
  output logic             busy,
  output logic             done,
  output logic             zero
`ifdef UREG_CARRY_EN
  ,
  output logic             carry
`endif
);

  typedef enum logic {StIdle, StRun} state_e;
  typedef enum logic [2:0] {
    OpHold = 3'b000,
    OpLoad = 3'b001,
    OpShl  = 3'b010,
    OpShr  = 3'b011,
    OpRol  = 3'b100,
    OpRor  = 3'b101,
    OpInc  = 3'b110,
    OpDec  = 3'b111
  } op_e;

  state_e           r_state;
  op_e              r_op;
  logic [AMT_W-1:0] r_cnt;
  logic [WIDTH-1:0] r_a;
  logic             r_sout;
  logic             r_done;

  logic [WIDTH-1:0] w_step_a;
  logic             w_out_bit;
  logic             w_sout_en;
  logic [AMT_W-1:0] w_count;

  // LOAD always takes exactly one step regardless of amt.
  assign w_count = (op_e'(op) == OpLoad) ? AMT_W'(1) : amt;

  always_comb begin
    w_step_a  = r_a;
    w_out_bit = 1'b0;
    w_sout_en = 1'b0;
    unique case (r_op)
      OpHold: w_step_a = r_a;
      OpLoad: w_step_a = i;
      OpShl: begin
        w_step_a  = {r_a[WIDTH-2:0], sin};
        w_out_bit = r_a[WIDTH-1];
        w_sout_en = 1'b1;
      end
      OpShr: begin
        w_step_a  = {sin, r_a[WIDTH-1:1]};
        w_out_bit = r_a[0];
        w_sout_en = 1'b1;
      end
      OpRol: begin
        w_step_a  = {r_a[WIDTH-2:0], r_a[WIDTH-1]};
        w_out_bit = r_a[WIDTH-1];
        w_sout_en = 1'b1;
      end
      OpRor: begin
        w_step_a  = {r_a[0], r_a[WIDTH-1:1]};
        w_out_bit = r_a[0];
        w_sout_en = 1'b1;
      end
      OpInc: w_step_a = r_a + WIDTH'(1);
      OpDec: w_step_a = r_a - WIDTH'(1);
    endcase
  end

  always_ff @(posedge clk) begin
    if (clear) begin
      r_state <= StIdle;
      r_op    <= OpHold;
      r_cnt   <= '0;
      r_a     <= '0;
      r_sout  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_done <= 1'b0;
      unique case (r_state)
        StIdle: begin
          if (start) begin
            r_op <= op_e'(op);
            if (w_count != '0) begin
              r_state <= StRun;
              r_cnt   <= w_count;
            end else begin
              r_done <= 1'b1;
            end
          end else if (load) begin
            r_a <= i;
          end
        end
        StRun: begin
          r_a   <= w_step_a;
          r_cnt <= r_cnt - AMT_W'(1);
          if (w_sout_en) r_sout <= w_out_bit;
          if (r_cnt == AMT_W'(1)) begin
            r_state <= StIdle;
            r_done  <= 1'b1;
          end
        end
      endcase
    end
  end

`ifdef UREG_CARRY_EN
  logic r_carry;
  logic w_ovf;

  // Sticky: overflow/borrow of INC/DEC and bits lost by SHL/SHR; rotates lose nothing.
  assign w_ovf = ((r_op == OpInc) && (&r_a)) || ((r_op == OpDec) && (~|r_a)) ||
                 (((r_op == OpShl) || (r_op == OpShr)) && w_out_bit);

  always_ff @(posedge clk) begin
    if (clear) begin
      r_carry <= 1'b0;
    end else if (r_state == StIdle && start) begin
      r_carry <= 1'b0;
    end else if (r_state == StRun) begin
      r_carry <= r_carry | w_ovf;
    end
  end

  assign carry = r_carry;
`endif

  assign a    = r_a;
  assign sout = r_sout;
  assign busy = (r_state == StRun);
  assign done = r_done;
  assign zero = (r_a == '0);

endmodule

// File: tb/tb_universal_reg_n.sv
// Bench for universal_reg_n: directed cycle table plus randomized run against an
// arithmetic reference model. Checks `carry` too when UREG_CARRY_EN is defined.
module tb_universal_reg_n;

  logic       clk = 1'b0;
  logic       clear, load, start, sin;
  logic [7:0] i;
  logic [2:0] op;
  logic [3:0] amt;
  logic [7:0] a;
  logic       sout, busy, done, zero;
  logic       carry;

  int n_tests = 0;
  int n_fail  = 0;

  universal_reg_n #(.WIDTH(8), .AMT_W(4)) dut (
    .clk   (clk),
    .clear (clear),
    .load  (load),
    .i     (i),
    .start (start),
    .op    (op),
    .amt   (amt),
    .sin   (sin),
    .a     (a),
    .sout  (sout),
    .busy  (busy),
    .done  (done),
    .zero  (zero)
`ifdef UREG_CARRY_EN
    ,
    .carry (carry)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       clr, ld, st;
    logic [2:0] op;
    logic [3:0] amt;
    logic       sin;
    logic [7:0] din;
    logic [7:0] ea;
    logic       eb, ed, es;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(logic c, logic l, logic s, logic [2:0] o, logic [3:0] am,
                              logic sn, logic [7:0] d, logic [7:0] ea, logic eb,
                              logic ed, logic es);
    vec_t v;
    v.clr = c; v.ld = l; v.st = s; v.op = o; v.amt = am; v.sin = sn; v.din = d;
    v.ea = ea; v.eb = eb; v.ed = ed; v.es = es;
    return v;
  endfunction

  task automatic drive(logic c, logic l, logic s, logic [2:0] o, logic [3:0] am,
                       logic sn, logic [7:0] d);
    clear = c; load = l; start = s; op = o; amt = am; sin = sn; i = d;
  endtask

  task automatic chk(string name, logic [7:0] ea, logic eb, logic ed, logic es);
    logic ez;
    ez = (ea == 8'h00);
    n_tests++;
    if (a !== ea || busy !== eb || done !== ed || sout !== es || zero !== ez) begin
      n_fail++;
      $display("FAIL %s: got a=%h busy=%b done=%b sout=%b zero=%b, want a=%h busy=%b done=%b sout=%b zero=%b",
               name, a, busy, done, sout, zero, ea, eb, ed, es, ez);
    end
  endtask

  // Reference model: remaining-steps counter plus arithmetic on integers.
  int m_a, m_left, m_op;
  bit m_sout, m_done, m_carry;

  task automatic model_edge(logic c, logic l, logic s, logic [2:0] o, logic [3:0] am,
                            logic sn, logic [7:0] d);
    int x, hi, lo, n;
    x  = m_a;
    hi = x / 128;
    lo = x % 2;
    if (c) begin
      x = 0; m_sout = 0; m_done = 0; m_left = 0; m_carry = 0;
    end else begin
      m_done = 0;
      if (m_left > 0) begin
        case (m_op)
          1: x = int'(d);
          2: begin m_sout = (hi != 0); m_carry |= (hi != 0); x = (x * 2 + int'(sn)) % 256; end
          3: begin m_sout = (lo != 0); m_carry |= (lo != 0); x = x / 2 + int'(sn) * 128; end
          4: begin m_sout = (hi != 0); x = (x * 2) % 256 + hi; end
          5: begin m_sout = (lo != 0); x = x / 2 + lo * 128; end
          6: begin if (x == 255) m_carry = 1; x = (x + 1) % 256; end
          7: begin if (x == 0) m_carry = 1; x = (x + 255) % 256; end
          default: ;
        endcase
        m_left--;
        if (m_left == 0) m_done = 1;
      end else if (s) begin
        m_op = int'(o);
        n = (o == 3'd1) ? 1 : int'(am);
        m_carry = 0;
        if (n == 0) m_done = 1;
        else m_left = n;
      end else if (l) begin
        x = int'(d);
      end
    end
    m_a = x;
  endtask

  initial begin
    drive(1'b1, 0, 0, 3'd0, 4'd0, 0, 8'h00);
    // Directed sequence: each row is inputs before an edge and outputs after it.
    vecs.push_back(mk(1, 0, 0, 3'd0, 4'd0, 0, 8'h00, 8'h00, 0, 0, 0)); // reset
    vecs.push_back(mk(0, 1, 0, 3'd0, 4'd0, 0, 8'hA5, 8'hA5, 0, 0, 0)); // legacy load
    vecs.push_back(mk(0, 0, 1, 3'd4, 4'd3, 0, 8'h00, 8'hA5, 1, 0, 0)); // ROL x3 accept
    vecs.push_back(mk(0, 0, 0, 3'd0, 4'd0, 0, 8'h00, 8'h4B, 1, 0, 1));
    vecs.push_back(mk(0, 0, 0, 3'd0, 4'd0, 0, 8'h00, 8'h96, 1, 0, 0));
    vecs.push_back(mk(0, 0, 0, 3'd0, 4'd0, 0, 8'h00, 8'h2D, 0, 1, 1));
    vecs.push_back(mk(0, 0, 0, 3'd0, 4'd0, 0, 8'h00, 8'h2D, 0, 0, 1));
    vecs.push_back(mk(0, 1, 0, 3'd0, 4'd0, 0, 8'hFE, 8'hFE, 0, 0, 1));
    vecs.push_back(mk(0, 0, 1, 3'd6, 4'd3, 0, 8'h00, 8'hFE, 1, 0, 1)); // INC x3 wrap
    vecs.push_back(mk(0, 0, 0, 3'd0, 4'd0, 0, 8'h00, 8'hFF, 1, 0, 1));
    vecs.push_back(mk(0, 0, 0, 3'd0, 4'd0, 0, 8'h00, 8'h00, 1, 0, 1));
    vecs.push_back(mk(0, 0, 0, 3'd0, 4'd0, 0, 8'h00, 8'h01, 0, 1, 1));
    vecs.push_back(mk(0, 0, 1, 3'd6, 4'd0, 0, 8'h00, 8'h01, 0, 1, 1)); // amt=0
    vecs.push_back(mk(0, 0, 0, 3'd0, 4'd0, 0, 8'h00, 8'h01, 0, 0, 1));
    vecs.push_back(mk(1, 0, 0, 3'd0, 4'd0, 0, 8'h00, 8'h00, 0, 0, 0));
    vecs.push_back(mk(0, 0, 1, 3'd3, 4'd5, 1, 8'h00, 8'h00, 1, 0, 0)); // SHR x5, sin=1
    vecs.push_back(mk(0, 0, 0, 3'd0, 4'd0, 1, 8'h00, 8'h80, 1, 0, 0));
    vecs.push_back(mk(0, 0, 0, 3'd0, 4'd0, 1, 8'h00, 8'hC0, 1, 0, 0));
    vecs.push_back(mk(1, 0, 0, 3'd0, 4'd0, 1, 8'h00, 8'h00, 0, 0, 0)); // clear mid-run
    vecs.push_back(mk(0, 0, 0, 3'd0, 4'd0, 1, 8'h00, 8'h00, 0, 0, 0));
    vecs.push_back(mk(0, 0, 0, 3'd0, 4'd0, 1, 8'h00, 8'h00, 0, 0, 0));
    vecs.push_back(mk(0, 1, 0, 3'd0, 4'd0, 0, 8'h11, 8'h11, 0, 0, 0));
    vecs.push_back(mk(0, 0, 1, 3'd6, 4'd2, 0, 8'h00, 8'h11, 1, 0, 0)); // INC x2
    vecs.push_back(mk(0, 1, 1, 3'd1, 4'd7, 0, 8'h3C, 8'h12, 1, 0, 0)); // ignored in RUN
    vecs.push_back(mk(0, 1, 0, 3'd0, 4'd0, 0, 8'h3C, 8'h13, 0, 1, 0));
    vecs.push_back(mk(0, 0, 1, 3'd1, 4'd0, 0, 8'h77, 8'h13, 1, 0, 0)); // op LOAD on done
    vecs.push_back(mk(0, 0, 0, 3'd0, 4'd0, 0, 8'h77, 8'h77, 0, 1, 0));
    vecs.push_back(mk(0, 0, 0, 3'd0, 4'd0, 0, 8'h00, 8'h77, 0, 0, 0));

    #1;
    foreach (vecs[k]) begin
      drive(vecs[k].clr, vecs[k].ld, vecs[k].st, vecs[k].op, vecs[k].amt, vecs[k].sin,
            vecs[k].din);
      @(posedge clk);
      #1;
      chk($sformatf("vec%0d", k), vecs[k].ea, vecs[k].eb, vecs[k].ed, vecs[k].es);
    end

    // Randomized phase; first cycle clears so model and DUT start aligned.
    m_a = 0; m_left = 0; m_op = 0; m_sout = 0; m_done = 0; m_carry = 0;
    for (int n = 0; n < 3000; n++) begin
      logic c, l, s, sn;
      logic [2:0] o;
      logic [3:0] am;
      logic [7:0] d;
      c  = (n == 0) || ($urandom_range(0, 99) < 2);
      l  = ($urandom_range(0, 99) < 30);
      s  = ($urandom_range(0, 99) < 30);
      o  = 3'($urandom_range(0, 7));
      am = ($urandom_range(0, 9) == 0) ? 4'd0 : 4'($urandom_range(0, 15));
      sn = 1'($urandom_range(0, 1));
      d  = 8'($urandom_range(0, 255));
      drive(c, l, s, o, am, sn, d);
      model_edge(c, l, s, o, am, sn, d);
      @(posedge clk);
      #1;
      chk($sformatf("rand%0d", n), 8'(m_a), (m_left > 0), m_done, m_sout);
`ifdef UREG_CARRY_EN
      n_tests++;
      if (carry !== m_carry) begin
        n_fail++;
        $display("FAIL carry%0d: got %b, want %b", n, carry, m_carry);
      end
`endif
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
